// File: rtl/fifo_flags.sv
// Purpose: single-clock FIFO for any depth, with count, almost/exact flags and sticky error flags.
// Latency: a push is visible in count next cycle; pop in cycle N gives read_data/read_valid in N+1.
// Backpressure: push while full (without pop) and pop while empty are dropped and set overflow/underflow.
module fifo_flags #(
  parameter int DATA_W    = 10,
  parameter int DEPTH     = 6,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       pop,
  output logic [DATA_W-1:0]          read_data,
  output logic                       read_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] read_data_q, read_data_d;
  logic              read_valid_q, read_valid_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              push_acc, pop_acc;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  // Acceptance and next-state; clear overrides everything except read_data.
  always_comb begin
    pop_acc      = 1'b0;
    push_acc     = 1'b0;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    read_data_d  = read_data_q;
    read_valid_d = 1'b0;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;

    if (clear) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      // A pop frees a slot in the same edge, so a full FIFO can take push+pop together.
      pop_acc  = pop && (count_q != '0);
      push_acc = push && ((count_q != DEPTH_C) || pop_acc);

      if (push && !push_acc) overflow_d  = 1'b1;
      if (pop && !pop_acc)   underflow_d = 1'b1;

      if (push_acc) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (pop_acc) begin
        rd_ptr_d     = ptr_inc(rd_ptr_q);
        read_data_d  = mem_q[rd_ptr_q];
        read_valid_d = 1'b1;
      end

      if (push_acc && !pop_acc)      count_d = count_q + CNT_W'(1);
      else if (pop_acc && !push_acc) count_d = count_q - CNT_W'(1);
    end
  end

  // Control and output registers, asynchronously reset.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Storage array; contents are don't-care after reset so it carries no reset.
  always_ff @(posedge clock) begin
    if (push_acc) mem_q[wr_ptr_q] <= data_in;
  end

  // Flags decode only the count register, keeping inputs off every output path.
  always_comb begin
    count        = count_q;
    full         = (count_q == DEPTH_C);
    empty        = (count_q == '0);
    almost_full  = (count_q >= AF_C);
    almost_empty = (count_q <= AE_C);
    read_data    = read_data_q;
    read_valid   = read_valid_q;
    overflow     = overflow_q;
    underflow    = underflow_q;
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Purpose: randomized + directed bench for fifo_flags using a queue-based reference model.
// Latency: expected read words are queued when a pop is issued and matched by an independent monitor.
// Backpressure: model rejects pushes when full (unless popping) and pops when empty, tracking sticky errors.
module tb_fifo_flags;

  localparam int DATA_W = 10;
  localparam int DEPTH  = 6;
  localparam int AF     = 5;
  localparam int AE     = 1;

  logic              clock = 1'b0;
  logic              rst_n = 1'b0;
  logic              clear = 1'b0;
  logic              push  = 1'b0;
  logic              pop   = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] read_data;
  logic              read_valid;
  logic [2:0]        count;
  logic              full, empty, almost_full, almost_empty, overflow, underflow;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  int mdl[$];
  int exp_q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;
  int last_rd = 0;

  fifo_flags #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE)) dut (
    .clock(clock), .rst_n(rst_n), .clear(clear), .push(push), .data_in(data_in),
    .pop(pop), .read_data(read_data), .read_valid(read_valid), .count(count),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic check_state();
    int n;
    n = mdl.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= AF));
    chk("almost_empty", int'(almost_empty), int'(n <= AE));
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("underflow", int'(underflow), int'(m_udf));
  endtask

  // Spec-level model of one clock edge's worth of requests.
  task automatic model_step(input bit p, input bit q, input bit c, input int d);
    bit pa, wa;
    if (c) begin
      mdl.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pa = q && (mdl.size() > 0);
      wa = p && ((mdl.size() < DEPTH) || pa);
      if (q && !pa) m_udf = 1'b1;
      if (p && !wa) m_ovf = 1'b1;
      if (pa) exp_q.push_back(mdl.pop_front());
      if (wa) mdl.push_back(d);
    end
  endtask

  // One cycle: check the state left by the previous edge, then present new requests.
  task automatic cyc(input bit p, input bit q, input bit c, input int d);
    @(negedge clock);
    check_state();
    push    = p;
    pop     = q;
    clear   = c;
    data_in = DATA_W'(d);
    model_step(p, q, c, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0);
  endtask

  // Mid-cycle asynchronous reset: outputs must clear without any clock edge.
  task automatic mid_reset();
    @(negedge clock);
    check_state();
    push = 1'b0; pop = 1'b0; clear = 1'b0;
    #2 rst_n = 1'b0;
    mdl.delete(); exp_q.delete();
    m_ovf = 1'b0; m_udf = 1'b0; last_rd = 0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_almost_empty", int'(almost_empty), 1);
    chk("rst_almost_full", int'(almost_full), 0);
    chk("rst_read_valid", int'(read_valid), 0);
    chk("rst_read_data", int'(read_data), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_underflow", int'(underflow), 0);
    @(negedge clock);
    @(negedge clock);
    rst_n = 1'b1;
  endtask

  // Monitor: matches every read_valid against the scoreboard and checks read_data holds otherwise.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (read_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read_valid", 1, 0);
        end else begin
          last_rd = exp_q.pop_front();
          chk("read_data", int'(read_data), last_rd);
        end
      end else begin
        chk("missing_read_valid", exp_q.size(), 0);
        exp_q.delete();
        chk("read_data_hold", int'(read_data), last_rd);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hold_rd;
    // Power-on reset and reset-state check.
    #12;
    chk("init_count", int'(count), 0);
    chk("init_empty", int'(empty), 1);
    chk("init_almost_empty", int'(almost_empty), 1);
    chk("init_read_valid", int'(read_valid), 0);
    @(negedge clock);
    rst_n = 1'b1;

    // Fill then drain.
    for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, 1'b0, i);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0);
    idle(2);

    // Pointer wrap past the last entry.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 16 + i);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 'h100 + i);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0);
    idle(2);

    // Simultaneous push/pop when full: 0x3FF comes out last.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 'h200 + i);
    cyc(1'b1, 1'b1, 1'b0, 'h3FF);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0);
    idle(1);

    // Simultaneous push/pop when empty: pop rejected, push kept.
    cyc(1'b1, 1'b1, 1'b0, 'h0AA);
    cyc(1'b0, 1'b1, 1'b0, 0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b1, 0);

    // Overflow, underflow, then clear with push and pop at count 3.
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, 1'b0, 'h300 + i);
    cyc(1'b1, 1'b0, 1'b0, 'h3EE);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 0);
    cyc(1'b0, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 'h050 + i);
    idle(1);
    hold_rd = int'(read_data);
    cyc(1'b1, 1'b1, 1'b1, 'h1AB);
    idle(1);
    chk("clear_read_data", int'(read_data), hold_rd);
    chk("clear_read_valid", int'(read_valid), 0);

    // Asynchronous reset at count 4, then first push lands in entry 0.
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0, 'h060 + i);
    mid_reset();
    cyc(1'b1, 1'b0, 1'b0, 'h055);
    cyc(1'b0, 1'b1, 1'b0, 0);
    idle(2);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
          $urandom_range(0, 99) < 2, int'($urandom_range(0, 1023)));
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
